// File: rtl/buffer_memory_pkg.sv
// rtl/buffer_memory_pkg.sv - shared defaults, entry layout and helpers for buffer memory blocks
package buffer_memory_pkg;

  // Default geometry of a buffer memory FIFO
  localparam int DEFAULT_DATA_WIDTH = 40;
  localparam int DEFAULT_DEPTH      = 4;

  // Entry layout: header bits sit above the payload inside DATA_WIDTH
  localparam int PAYLOAD_LSB   = 0;
  localparam int PAYLOAD_WIDTH = 32;
  localparam int HDR_LSB       = PAYLOAD_LSB + PAYLOAD_WIDTH;
  localparam int HDR_WIDTH     = 8;
  localparam int HDR_LAST_BIT  = HDR_LSB + 0;
  localparam int HDR_ERR_BIT   = HDR_LSB + 1;
  localparam int HDR_TAG_LSB   = HDR_LSB + 2;
  localparam int HDR_TAG_WIDTH = 6;

  typedef struct packed {
    logic [HDR_TAG_WIDTH-1:0] tag;
    logic                     err;
    logic                     last;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } bm_entry_t;

  // Width needed to hold an occupancy value of 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width needed to index depth slots; never below one bit
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/buffer_memory_ptr.sv
// rtl/buffer_memory_ptr.sv - wrapping slot pointer with enable, sync clear and async reset
module buffer_memory_ptr
  import buffer_memory_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int PTR_WIDTH = ptr_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic [PTR_WIDTH-1:0] ptr_o
);

  // Wrap is an explicit compare so non-power-of-two depths work
  localparam logic [PTR_WIDTH-1:0] LAST_SLOT = PTR_WIDTH'(DEPTH - 1);

  logic [PTR_WIDTH-1:0] ptr_q;
  logic [PTR_WIDTH-1:0] ptr_d;

  // Next pointer: clear wins over advance, advance wraps LAST_SLOT -> 0
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = (ptr_q == LAST_SLOT) ? '0 : ptr_q + PTR_WIDTH'(1);
    end
  end

  // Pointer register, cleared asynchronously on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/buffer_memory_fifo.sv
// rtl/buffer_memory_fifo.sv - DEPTH-entry first-word-fall-through buffer memory FIFO
module buffer_memory_fifo
  import buffer_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int CNT_WIDTH  = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_empty,
  output logic                  out_full,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                   PTR_WIDTH = ptr_width(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 empty_q;
  logic                 empty_d;
  logic                 full_q;
  logic                 full_d;
  logic                 overflow_q;
  logic                 overflow_d;
  logic                 underflow_q;
  logic                 underflow_d;

  logic rd_acc;
  logic wr_acc;
  logic mem_we;

  // Acceptance: a pop needs data; a push needs room, or a pop in the same cycle
  always_comb begin
    rd_acc = read & ~empty_q;
    wr_acc = write & (~full_q | rd_acc);
    mem_we = wr_acc & ~flush;
  end

  buffer_memory_ptr #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr_i (flush),
    .en_i  (wr_acc),
    .ptr_o (wr_ptr)
  );

  buffer_memory_ptr #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr_i (flush),
    .en_i  (rd_acc),
    .ptr_o (rd_ptr)
  );

  // Storage write; contents are not reset, a flush-cycle write is dropped
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr] <= in_data;
    end
  end

  // Next occupancy, status flags and sticky error flags; flush overrides all
  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CNT_WIDTH'(1);
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - CNT_WIDTH'(1);
      end
      if (write && !wr_acc) begin
        overflow_d = 1'b1;
      end
      if (read && empty_q) begin
        underflow_d = 1'b1;
      end
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
  end

  // Status registers, cleared asynchronously to the empty state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Head entry falls through combinationally, forced to zero while empty
  always_comb begin
    out_data = '0;
    if (!empty_q) begin
      out_data = mem_q[rd_ptr];
    end
  end

  assign out_empty = empty_q;
  assign out_full  = full_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
